hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage MIPS subset (add, lw, sw, beq).
//  Samples decoded fields from ID and keeps a shadow record of the instructions in EX, MEM and WB.
//  Drives PC/IF-ID stalls, ID/EX bubbles and IF-ID flushes, plus EX-stage forwarding selects.
//  Counts stall and flush cycles for performance checks.
// PARAMETERS
//  REG_ADDR_W  5   register-index width
//  CNT_W       16  width of the stall/flush counters (saturating)
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      synchronous, active-high reset
//  id_valid         in   1      ID holds a real instruction (0 after flush or at start-up)
//  id_opcode        in   6      opcode of the ID instruction
//  id_rs            in   5      rs field of the ID instruction
//  id_rt            in   5      rt field of the ID instruction
//  id_rd            in   5      destination from ID (rd for add, rt for lw/sw, 0 for beq)
//  ex_branch_taken  in   1      beq in EX resolved taken (single-cycle pulse)
//  pc_stall         out  1      hold the PC
//  ifid_stall       out  1      hold the IF/ID register
//  idex_bubble      out  1      load a NOP into ID/EX this cycle
//  ifid_flush       out  1      clear IF/ID this cycle
//  fwd_a            out  2      EX operand A: 00 regfile, 01 EX/MEM, 10 MEM/WB
//  fwd_b            out  2      EX operand B: same encoding
//  stall_cnt        out  CNT_W  total stall cycles since reset
//  flush_cnt        out  CNT_W  total taken-branch flushes since reset
// BEHAVIOUR
//  - Decode: add reads rs and rt and writes rd. lw reads rs and writes rt. sw reads rs and rt, no write.
//    beq reads rs and rt, no write. Other opcodes read nothing and write nothing.
//  - Register 0 never causes a hazard and is never forwarded.
//  - Shadow pipeline: each entry is {valid, wen, is_load, dest, src_a, src_b}.
//    Every cycle WB<=MEM and MEM<=EX.
//    EX<=ID entry, or an invalid entry when idex_bubble=1 or id_valid=0.
//  - The register file writes before it reads, so an instruction in WB never forces a stall.
//  - FSM states RUN and STALL. In RUN, a hazard (defined under CONFIGURATION) moves it to STALL.
//    STALL returns to RUN in the first cycle with no hazard.
//    During a stall: pc_stall=ifid_stall=idex_bubble=1 and ifid_flush=0.
//  - Taken branch: when ex_branch_taken=1, ifid_flush=1 and idex_bubble=1 in that same cycle.
//    The stall outputs are forced to 0 and the FSM goes to RUN (the flush wins over a stall).
//    Both wrong-path instructions are discarded, giving a 2-cycle penalty.
//  - Outputs are combinational from the current state, the shadow entries and the ID/branch inputs.
//  - Forwarding selects apply to the instruction currently in the EX shadow entry:
//    - EX.src_a matches a valid, writing MEM entry (not a load) -> fwd_a=01.
//    - Otherwise EX.src_a matches a valid, writing WB entry -> fwd_a=10.
//    - Otherwise fwd_a=00. MEM has priority over WB. fwd_b uses the same rule with src_b.
//  - stall_cnt increments on every stall cycle. flush_cnt increments on every cycle with ex_branch_taken=1.
//    Both counters saturate at all-ones.
//  - Reset: all shadow entries invalid, FSM=RUN, counters=0.
//    All control outputs are 0 and fwd_a=fwd_b=00 in the cycle after reset is sampled.
//    Reset in the middle of a stall ends the stall immediately.
// CONFIGURATION
//  - HAZARD_FWD_EN defined: forwarding is active.
//    A hazard exists only for load-use: a source of the ID instruction equals EX.dest, with EX valid, EX.is_load=1 and dest!=0.
//    This costs exactly 1 stall cycle; after it the loaded value comes from MEM/WB (fwd=10).
//  - HAZARD_FWD_EN undefined: fwd_a and fwd_b are tied to 00.
//    A hazard exists when any ID source equals the dest of a valid, writing EX or MEM entry (dest!=0).
//    The stall lasts until that writer reaches WB: 2 cycles for a dependency on EX, 1 cycle for one on MEM.
// TESTING
//  - FWD_EN on: lw $2,0($1) then add $3,$2,$4 -> 1 stall cycle (stall_cnt=1); when the add is in EX, fwd_a=10.
//  - FWD_EN on: add $5,$1,$2 then sw $5,4($6) -> no stall; when the sw is in EX, fwd_b=01.
//    With one NOP between them, fwd_b=10.
//  - FWD_EN off: add $5,$1,$2 then add $6,$5,$5 -> pc_stall held 2 cycles; fwd_a=fwd_b=00 throughout.
//  - Taken beq in EX while ID holds lw-dependent add -> ifid_flush=1, idex_bubble=1, pc_stall=0;
//    flush_cnt=1, stall_cnt unchanged.
//  - add $0,$1,$2 then add $3,$0,$0 -> no stall, fwd_a=fwd_b=00.
//  - Reset asserted in a stall cycle -> next cycle all outputs 0, counters 0, FSM=RUN.
//    Counter saturation: force 2^CNT_W+3 stalls -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// ID-stage decode fields, branch resolution and the stall/flush/forward controls
// exchanged between the pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [5:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_branch_taken;
  logic                  pc_stall;
  logic                  ifid_stall;
  logic                  idex_bubble;
  logic                  ifid_flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage add/lw/sw/beq pipeline; controls are combinational.
// Build macro HAZARD_FWD_EN enables EX forwarding (load-use stalls only); default stalls until the writer reaches WB.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);
  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, STALL} state_e;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src_a;
    logic [REG_ADDR_W-1:0] src_b;
  } entry_t;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic writes_reg(entry_t e, logic [REG_ADDR_W-1:0] r);
    return e.valid && e.wen && (e.dest != '0) && (e.dest == r);
  endfunction

  state_e           state_q, state_d;
  entry_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  entry_t           id_e;
  logic             hazard;
  logic             stall;
  logic             branch;
  logic             unused_bits;

  always_comb begin : decode
    id_e       = '0;
    id_e.valid = hif.id_valid;
    case (hif.id_opcode)
      OP_ADD: begin
        id_e.wen   = 1'b1;
        id_e.dest  = hif.id_rd;
        id_e.src_a = hif.id_rs;
        id_e.src_b = hif.id_rt;
      end
      OP_LW: begin
        id_e.wen     = 1'b1;
        id_e.is_load = 1'b1;
        id_e.dest    = hif.id_rd;
        id_e.src_a   = hif.id_rs;
      end
      OP_SW, OP_BEQ: begin
        id_e.src_a = hif.id_rs;
        id_e.src_b = hif.id_rt;
      end
      default: ;
    endcase
  end

  always_comb begin : detect
    hazard = 1'b0;
`ifdef HAZARD_FWD_EN
    if (id_e.valid && ex_q.is_load)
      hazard = writes_reg(ex_q, id_e.src_a) || writes_reg(ex_q, id_e.src_b);
`else
    // WB writes before the regfile read, so only EX and MEM writers block.
    if (id_e.valid)
      hazard = writes_reg(ex_q, id_e.src_a)  || writes_reg(ex_q, id_e.src_b) ||
               writes_reg(mem_q, id_e.src_a) || writes_reg(mem_q, id_e.src_b);
`endif
  end

  always_comb begin : fsm
    state_d = state_q;
    branch  = hif.ex_branch_taken;
    stall   = 1'b0;
    // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
    case (state_q)
      RUN: begin
        if (hazard && !branch) begin
          stall   = 1'b1;
          state_d = STALL;
        end
      end
      STALL: begin
        if (hazard && !branch) stall = 1'b1;
        else                   state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    hif.pc_stall    = stall;
    hif.ifid_stall  = stall;
    hif.idex_bubble = stall || branch;
    hif.ifid_flush  = branch;
  end

  always_comb begin : shadow
    ex_d  = (stall || branch || !hif.id_valid) ? '0 : id_e;
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_comb begin : counters
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX))  stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (branch && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
    hif.stall_cnt = stall_cnt_q;
    hif.flush_cnt = flush_cnt_q;
  end

  always_comb begin : forward
    hif.fwd_a = 2'b00;
    hif.fwd_b = 2'b00;
`ifdef HAZARD_FWD_EN
    // A load in MEM has no data yet; load-use stalls push it to WB first.
    if (writes_reg(mem_q, ex_q.src_a) && !mem_q.is_load) hif.fwd_a = 2'b01;
    else if (writes_reg(wb_q, ex_q.src_a))               hif.fwd_a = 2'b10;
    if (writes_reg(mem_q, ex_q.src_b) && !mem_q.is_load) hif.fwd_b = 2'b01;
    else if (writes_reg(wb_q, ex_q.src_b))               hif.fwd_b = 2'b10;
    unused_bits = ^{wb_q.is_load, wb_q.src_a, wb_q.src_b};
`else
    unused_bits = ^wb_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule
